ex_mux_sel_arbiter: RTL
=======================

// Module: ex_mux_sel_arbiter
// PURPOSE
//  Round-robin arbiter that drives the select inputs of the 6-input, 4-bit priority mux.
//  Six sources (a..f) request the mux output. One source is granted at a time.
//  The grant is encoded onto sel1..sel5 so that the downstream mux forwards that source.
//  Grant is held until the source finishes, drops its request, or hits a hold limit.
// PARAMETERS
//  HOLD_MAX  4  max cycles one grant may stay active (1..2**CNT_W-1)
//  CNT_W     3  width of the hold counter
// PORTS
//  clk        in   1  rising-edge clock
//  rst        in   1  synchronous, active-high reset
//  req        in   6  request vector; bit0=a, bit1=b, ... bit5=f
//  done       in   1  pulse from the granted source: transfer finished
//  gnt        out  6  one-hot grant, same bit order as req; 0 when idle
//  gnt_valid  out  1  high while a grant is active
//  sel1..sel5 out  1  each; mux selects, registered
// BEHAVIOUR
//  - All outputs are registered. rst has priority over everything else.
//    On an rst edge: state=IDLE, gnt=0, gnt_valid=0, sel1..5=0, rr pointer=0 (a), hold count=0.
//  - FSM states: IDLE, GRANT.
//  - IDLE, req==0: stay in IDLE; outputs remain 0.
//  - IDLE, req!=0 at an edge:
//    - Scan req starting at the rr pointer and wrapping 5->0; the first set bit wins.
//    - At the same edge: gnt=onehot(winner), gnt_valid=1, sel per encoding, count=1; go to GRANT.
//    - Latency: req sampled at edge N, grant visible after edge N.
//  - GRANT: release at an edge when any of these is true:
//    - done=1
//    - req[granted]=0
//    - count==HOLD_MAX
//  - On release: go to IDLE; gnt=0, gnt_valid=0, sel=0; pointer=(granted+1) mod 6.
//    Otherwise count increments.
//  - Grant therefore lasts 1..HOLD_MAX cycles.
//    There is always exactly one idle bubble cycle between consecutive grants; no back-to-back grants.
//  - Requests from other sources during GRANT are ignored until IDLE; no pre-emption.
//  - Simultaneous release causes (e.g. done and count==HOLD_MAX) count as a single release.
//  - Select encoding (sel1..sel5):
//    - a=1xxxx -> 10000
//    - b=01100
//    - c=01000
//    - d=00010
//    - e=00001
//    - f=00000
//  - Idle selects are 00000, which equals the f code. The consumer must qualify with gnt_valid.
//  - Pointer wraps f->a. Fairness: with all 6 requesting continuously, each source gets one grant per 6 grants.
//  - rst asserted mid-grant: grant cleared at that edge, no release bookkeeping, pointer returns to a.
// TESTING
//  1. rst, then req=6'b000001 -> after 1 edge: gnt=000001, gnt_valid=1, sel=10000.
//     Hold req, done=0 -> released after 4 grant cycles, 1 idle cycle, then re-granted.
//  2. req=6'b111111 held, done=0 -> grant order a,b,c,d,e,f,a.
//     Each grant lasts 4 cycles with 1 bubble between; sel codes 10000,01100,01000,00010,00001,00000.
//  3. req=6'b000100 (c), done pulsed in the 2nd grant cycle -> gnt=0 after that edge.
//     Next grant with req=6'b000101 goes to a (pointer=d, wraps to a).
//  4. Grant held by b, req[1] dropped in cycle 1 -> release at that edge; pointer=c.
//     With req=6'b100010, next grant goes to f.
//  5. rst pulsed in cycle 2 of a grant to d -> all outputs 0 after the edge.
//     With req=6'b111111, next grant goes to a.
//  6. HOLD_MAX=1 build, req=6'b111111 -> 1-cycle grants alternating with 1 idle cycle, rotating a..f.

Source files
------------

// File: rtl/ex_mux_sel_arbiter.sv
// Round-robin arbiter for the 6-input priority mux selects.
// One grant at a time, held until done, request drop, or hold limit.
module ex_mux_sel_arbiter #(
    parameter int HOLD_MAX = 4,
    parameter int CNT_W    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] req,
    input  logic       done,
    output logic [5:0] gnt,
    output logic       gnt_valid,
    output logic       sel1,
    output logic       sel2,
    output logic       sel3,
    output logic       sel4,
    output logic       sel5
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state, state_nxt;
    logic [2:0]       ptr, ptr_nxt;
    logic [2:0]       gidx, gidx_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [5:0]       gnt_nxt;
    logic             vld_nxt;
    logic [4:0]       sel, sel_nxt;
    logic [2:0]       win;
    logic             hit;
    logic [3:0]       scan;
    logic             release_now;

    // Mux select code for each source; f shares the all-zero idle code.
    function automatic logic [4:0] enc(input logic [2:0] idx);
        logic [4:0] code;
        case (idx)
            3'd0:    code = 5'b10000;
            3'd1:    code = 5'b01100;
            3'd2:    code = 5'b01000;
            3'd3:    code = 5'b00010;
            3'd4:    code = 5'b00001;
            default: code = 5'b00000;
        endcase
        return code;
    endfunction

    always_comb begin
        win  = '0;
        hit  = 1'b0;
        scan = '0;
        for (int i = 0; i < 6; i++) begin
            scan = {1'b0, ptr} + 4'(i);
            if (scan >= 4'd6) scan = scan - 4'd6;
            if (!hit && req[scan[2:0]]) begin
                hit = 1'b1;
                win = scan[2:0];
            end
        end
    end

    assign release_now = done || !req[gidx] ||
                         (cnt == CNT_W'(HOLD_MAX));

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        gidx_nxt  = gidx;
        cnt_nxt   = cnt;
        gnt_nxt   = gnt;
        vld_nxt   = gnt_valid;
        sel_nxt   = sel;
        case (state)
            IDLE: begin
                if (hit) begin
                    state_nxt = GRANT;
                    gidx_nxt  = win;
                    cnt_nxt   = CNT_W'(1);
                    gnt_nxt   = 6'(1) << win;
                    vld_nxt   = 1'b1;
                    sel_nxt   = enc(win);
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    vld_nxt   = 1'b0;
                    sel_nxt   = '0;
                    cnt_nxt   = '0;
                    ptr_nxt   = (gidx == 3'd5) ? 3'd0 : gidx + 3'd1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            gidx      <= '0;
            cnt       <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            sel       <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            gidx      <= gidx_nxt;
            cnt       <= cnt_nxt;
            gnt       <= gnt_nxt;
            gnt_valid <= vld_nxt;
            sel       <= sel_nxt;
        end
    end

    assign {sel1, sel2, sel3, sel4, sel5} = sel;

endmodule
